// File: rtl/regfile_dump.sv
// Debug read-out engine: walks the register file debug port and streams each register as bytes.
// Optional `REGDUMP_HEX_EN selects ASCII-hex output (9 bytes/register) instead of raw binary (4 bytes/register).
module regfile_dump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  dbg_reg_sel,
  input  logic [31:0] dbg_reg_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

`ifdef REGDUMP_HEX_EN
  localparam int BYTES   = 9;
  localparam int SHIFT_W = 4;
`else
  localparam int BYTES   = 4;
  localparam int SHIFT_W = 8;
`endif

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);
  localparam logic [3:0] LAST_CNT  = 4'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  idx_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] shreg_p1;
  logic        xfer;

`ifdef REGDUMP_HEX_EN
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h57 + {4'h0, nib};
  endfunction
`endif

  assign tx_valid = (state == SEND);
  assign busy     = (state == LOAD) || (state == SEND);
  assign done     = (state == DONE);
  assign xfer     = tx_valid && tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dbg_reg_sel <= 5'd0;
      cnt         <= 4'd0;
    end else begin
      state       <= state_nxt;
      dbg_reg_sel <= idx_nxt;
      cnt         <= cnt_nxt;
    end
  end

  // Snapshot stage: each register is captured in its own LOAD cycle, then shifted out MSB first
  always_ff @(posedge clk) begin
    if (state == LOAD)
      shreg_p1 <= dbg_reg_data;
    else if (xfer)
      shreg_p1 <= shreg_p1 << SHIFT_W;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = dbg_reg_sel;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          idx_nxt   = FIRST_IDX;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        cnt_nxt   = 4'd0;
        state_nxt = SEND;
      end
      SEND: begin
        if (xfer) begin
          if (cnt == LAST_CNT) begin
            if (dbg_reg_sel == LAST_IDX) begin
              state_nxt = DONE;
            end else begin
              idx_nxt   = dbg_reg_sel + 5'd1;
              state_nxt = LOAD;
            end
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output byte is forced to zero outside SEND so the idle value is deterministic
  always_comb begin
    tx_data = 8'h00;
    if (state == SEND) begin
`ifdef REGDUMP_HEX_EN
      if (cnt == LAST_CNT) tx_data = 8'h0A;
      else                 tx_data = hex_ascii(shreg_p1[31:28]);
`else
      tx_data = shreg_p1[31:24];
`endif
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: full-range DUT plus a 1..2 range DUT sharing one register file model.
`timescale 1ns/1ps
module tb_regfile_dump;

`ifdef REGDUMP_HEX_EN
  localparam int B = 9;
`else
  localparam int B = 4;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start0, start1, ready0, ready1;
  logic        busy0, done0, valid0, busy1, done1, valid1;
  logic [4:0]  sel0, sel1;
  logic [7:0]  data0, data1;
  logic [31:0] rd0, rd1;
  logic [31:0] regs [32];
  logic [31:0] exp_regs [32];

  assign rd0 = (sel0 == 5'd0) ? 32'h0 : regs[sel0];
  assign rd1 = (sel1 == 5'd0) ? 32'h0 : regs[sel1];

  regfile_dump dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .dbg_reg_sel(sel0), .dbg_reg_data(rd0), .tx_data(data0), .tx_valid(valid0), .tx_ready(ready0)
  );

  regfile_dump #(.FIRST_REG(1), .LAST_REG(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .dbg_reg_sel(sel1), .dbg_reg_data(rd1), .tx_data(data1), .tx_valid(valid1), .tx_ready(ready1)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int nbytes0 = 0, nbytes1 = 0, ndone0 = 0, ndone1 = 0, done_cyc0 = 0, done_cyc1 = 0;
  logic stall0 = 1'b0;
  logic [7:0] hold0 = 8'h00;
  bit rnd_mode = 0;
  bit ready_lvl = 1;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Independent byte encoder: hex digits via a lookup string, raw bytes via shifting
  task automatic push_reg(input bit which, input logic [31:0] v);
    string hex = "0123456789abcdef";
    logic [7:0] b;
`ifdef REGDUMP_HEX_EN
    for (int i = 0; i < 8; i++) begin
      b = hex.getc(int'((v >> (28 - 4 * i)) & 32'hF));
      if (which) q1.push_back(b); else q0.push_back(b);
    end
    if (which) q1.push_back(8'h0A); else q0.push_back(8'h0A);
`else
    for (int i = 0; i < 4; i++) begin
      b = 8'((v >> (24 - 8 * i)) & 32'hFF);
      if (which) q1.push_back(b); else q0.push_back(b);
    end
`endif
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    ready0 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready0 = rnd_mode ? ($urandom_range(0, 99) < 30) : ready_lvl;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall0) begin
        chk_eq("hold_valid0", {31'h0, valid0}, 32'h1);
        chk_eq("hold_data0", {24'h0, data0}, {24'h0, hold0});
      end
      if (valid0 && ready0) begin
        chk_eq("byte0_expected", {31'h0, q0.size() != 0}, 32'h1);
        if (q0.size() != 0) chk_eq("byte0", {24'h0, data0}, {24'h0, q0.pop_front()});
        nbytes0 <= nbytes0 + 1;
      end
      stall0 <= valid0 && !ready0;
      hold0  <= data0;
      if (done0) begin
        ndone0    <= ndone0 + 1;
        done_cyc0 <= cyc;
      end
      if (valid1 && ready1) begin
        chk_eq("byte1_expected", {31'h0, q1.size() != 0}, 32'h1);
        if (q1.size() != 0) chk_eq("byte1", {24'h0, data1}, {24'h0, q1.pop_front()});
        nbytes1 <= nbytes1 + 1;
      end
      if (done1) begin
        ndone1    <= ndone1 + 1;
        done_cyc1 <= cyc;
      end
    end else begin
      stall0 <= 1'b0;
    end
  end

  task automatic push_dump0();
    for (int r = 0; r < 32; r++) push_reg(0, (r == 0) ? 32'h0 : exp_regs[r]);
  endtask

  // Returns cyc value of the cycle in which start was driven
  task automatic start_dump0(output int s);
    @(negedge clk);
    start0 = 1'b1;
    s = cyc;
    @(negedge clk);
    start0 = 1'b0;
    chk_eq("lat_load_busy", {31'h0, busy0}, 32'h1);
    chk_eq("lat_load_novalid", {31'h0, valid0}, 32'h0);
    @(negedge clk);
    chk_eq("lat_first_valid", {31'h0, valid0}, 32'h1);
  endtask

  task automatic wait_done0(input string tag, input int s, input bit check_lat, input int nb0);
    int n = ndone0;
    for (int i = 0; i < 6000 && ndone0 == n; i++) @(negedge clk);
    chk_eq({tag, "_done_seen"}, {31'h0, ndone0 != n}, 32'h1);
    if (check_lat) chk_eq({tag, "_done_latency"}, done_cyc0 - s + 1, 32 * (B + 1) + 2);
    chk_eq({tag, "_done_pulse"}, {31'h0, done0}, 32'h0);
    chk_eq({tag, "_busy_after"}, {31'h0, busy0}, 32'h0);
    chk_eq({tag, "_byte_count"}, nbytes0 - nb0, 32 * B);
    chk_eq({tag, "_queue_drained"}, q0.size(), 0);
  endtask

  initial begin
    int s, nb, nd;
    bit found;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; ready1 = 1'b1;
    for (int r = 0; r < 32; r++) regs[r] = 32'h0;
    #2;
    chk_eq("rst_busy", {31'h0, busy0}, 32'h0);
    chk_eq("rst_done", {31'h0, done0}, 32'h0);
    chk_eq("rst_valid", {31'h0, valid0}, 32'h0);
    chk_eq("rst_data", {24'h0, data0}, 32'h0);
    chk_eq("rst_sel", {27'h0, sel0}, 32'h0);
    chk_eq("rst_valid1", {31'h0, valid1}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full dump, x5 = DEADBEEF
    regs[5] = 32'hDEADBEEF;
    exp_regs = regs;
    push_dump0();
    nb = nbytes0;
    start_dump0(s);
    wait_done0("full", s, 1, nb);

    // Small-range DUT, raw or hex of x1/x2
    regs[1] = 32'h12345678; regs[2] = 32'h00000001;
    push_reg(1, 32'h12345678); push_reg(1, 32'h00000001);
    nb = nbytes1; nd = ndone1;
    @(negedge clk); start1 = 1'b1; s = cyc;
    @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < 200 && ndone1 == nd; i++) @(negedge clk);
    chk_eq("range_done_latency", done_cyc1 - s + 1, 2 * (B + 1) + 2);
    repeat (5) @(negedge clk);
    chk_eq("range_done_count", ndone1 - nd, 1);
    chk_eq("range_byte_count", nbytes1 - nb, 2 * B);
    chk_eq("range_queue_drained", q1.size(), 0);
    regs[1] = 32'h0; regs[2] = 32'h0;

    // Backpressure with ~30% ready duty, same content as the full dump
    exp_regs = regs;
    push_dump0();
    nb = nbytes0;
    rnd_mode = 1;
    start_dump0(s);
    wait_done0("bp", s, 0, nb);
    rnd_mode = 0;
    repeat (2) @(negedge clk);

    // Start pulses mid-dump and during DONE are ignored
    push_dump0();
    nb = nbytes0; nd = ndone0;
    start_dump0(s);
    repeat (50) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (done0) found = 1;
    end
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (40) @(negedge clk);
    chk_eq("busy_start_done_seen", {31'h0, found}, 32'h1);
    chk_eq("busy_start_done_count", ndone0 - nd, 1);
    chk_eq("busy_start_byte_count", nbytes0 - nb, 32 * B);
    chk_eq("busy_start_idle", {31'h0, busy0}, 32'h0);

    // Reset while byte 4 of register 10 is presented and stalled
    push_dump0();
    nb = nbytes0;
    start_dump0(s);
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (valid0 && ready0 && (nbytes0 - nb) == 10 * B + 2) begin
        ready_lvl = 0;
        found = 1;
      end
    end
    chk_eq("rst_point_found", {31'h0, found}, 32'h1);
    @(negedge clk);
    chk_eq("mid_sel_before_rst", {27'h0, sel0}, 32'd10);
    chk_eq("mid_valid_before_rst", {31'h0, valid0}, 32'h1);
    nd = ndone0;
    #1 rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_valid", {31'h0, valid0}, 32'h0);
    chk_eq("mid_rst_busy", {31'h0, busy0}, 32'h0);
    chk_eq("mid_rst_sel", {27'h0, sel0}, 32'h0);
    q0.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_lvl = 1;
    repeat (3) @(negedge clk);
    chk_eq("mid_rst_no_done", ndone0 - nd, 0);
    push_dump0();
    nb = nbytes0;
    start_dump0(s);
    chk_eq("restart_first_sel", {27'h0, sel0}, 32'd0);
    wait_done0("restart", s, 1, nb);

    // Non-atomic snapshot: x20 updated (before its LOAD), x2 updated after its LOAD
    regs[2] = 32'h11111111; regs[5] = 32'h0;
    exp_regs = regs;
    exp_regs[20] = 32'hCAFEF00D;
    push_dump0();
    nb = nbytes0;
    start_dump0(s);
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (valid0 && sel0 == 5'd3) found = 1;
    end
    chk_eq("snap_reg3_reached", {31'h0, found}, 32'h1);
    regs[20] = 32'hCAFEF00D;
    regs[2]  = 32'hFFFFFFFF;
    wait_done0("snap", s, 1, nb);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
